quant_seq_ctrl: RTL
===================

Name: quant_seq_ctrl

Overview:
- Sequencer for the JPEG quantization stage. It owns one 12x23 unsigned multiplier instance (mul_Q) and a 64-entry reciprocal quant table.
- Accepts signed DCT coefficients in block order, one at a time. Multiplies each magnitude by the table reciprocal for its position, then rounds, shifts, restores the sign and saturates.
- Emits quantized coefficients to the entropy-coding front end over a valid/ready stream, and tracks the 8x8 block position.

Parameters:
- FRAC_W, 12: fractional bits of the reciprocal (Q0.12). Product is shifted right by FRAC_W.
- OUT_W, 12: signed output width. Results saturate to ±(2^(OUT_W-1)-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_valid  in  1  input coefficient valid.
- coef_ready  out  1  sequencer can accept a coefficient.
- coef_sign  in  1  1 = negative coefficient.
- coef_mag  in  23  coefficient magnitude, unsigned.
- tbl_we  in  1  reciprocal table write strobe.
- tbl_addr  in  6  table write index (0..63).
- tbl_wdata  in  12  reciprocal value, unsigned Q0.12.
- tbl_busy  out  1  1 while a block is in progress; table writes are ignored.
- q_valid  out  1  quantized output valid.
- q_ready  in  1  downstream accepts output.
- q_data  out  OUT_W  quantized coefficient, two's complement.
- q_last  out  1  marks the 64th coefficient of a block.
- q_sat  out  1  saturation occurred on this output.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - coef_ready=0, q_valid=0, q_data=0, q_last=0, q_sat=0, tbl_busy=0.
  - idx=0, state=S_IDLE.
  - Table contents are NOT reset. The bench loads all 64 entries before use.
- FSM states: S_IDLE, S_MUL, S_OUT.
  - S_IDLE: coef_ready=1. On coef_valid, register {coef_sign, coef_mag} and recip=tbl[idx], then go to S_MUL.
  - S_MUL: coef_ready=0. Registered operands drive mul_Q, A=mag, B=recip.
    - Compute r = (product + 2^(FRAC_W-1)) >> FRAC_W, using 36-bit arithmetic so there is no overflow.
    - If r > 2^(OUT_W-1)-1: r is clamped and q_sat=1.
    - If sign=1 and r≠0: q_data=-r. Otherwise q_data=r. Negative zero outputs 0.
    - q_last=(idx==63). Register all outputs, set q_valid=1, go to S_OUT.
  - S_OUT: hold q_data, q_last and q_sat stable while q_valid=1 and q_ready=0.
    - On q_ready: q_valid=0, idx increments (63 wraps to 0), go to S_IDLE.
- Throughput: at most one coefficient per 3 cycles. Input-accept to q_valid latency is 2 cycles (q_valid rises at the 2nd edge after acceptance).
- Table writes:
  - tbl_busy = (idx≠0) or (state≠S_IDLE).
  - tbl_we is honoured only when tbl_busy=0. Otherwise it is dropped silently.
  - A write and a coefficient accept in the same S_IDLE cycle: the accept reads the OLD table value, and the write takes effect afterwards.
- Reset mid-block: all state returns to reset values immediately, idx=0 and no output is emitted. The next coefficient is treated as position 0.
- Handshake: q_valid, once asserted, never drops without q_ready. coef_ready depends only on state, never combinationally on q_ready.

Optional Feature:
- Macro QUANT_ROUND_EN.
  - Defined: round-half-up, adding 2^(FRAC_W-1) before the shift, as above.
  - Undefined: truncate, r = product >> FRAC_W with no rounding addend. All other behaviour is identical.

Test Plan:
- Load tbl[0]=2048 (0.5). Send sign=0, mag=100 → q_data=50, q_sat=0, q_last=0. q_valid rises 2 cycles after accept.
- Load tbl[1]=2048. Send coefficient 0 then sign=1, mag=101 → second output q_data=-51 with QUANT_ROUND_EN, -50 without. Also sign=1, mag=0 → q_data=0.
- Load tbl[0]=4095. Send mag=1000000, sign=0 → q_data=2047, q_sat=1. Send sign=1 → q_data=-2047, q_sat=1.
- Stream 64 coefficients with q_ready toggling 1/0:
  - exactly 64 outputs;
  - q_last=1 only on the 64th;
  - q_data stable during stalls;
  - idx back to 0 and tbl_busy=0 afterwards.
- Mid-block (idx=5), write tbl[0]=100 → write ignored, tbl[0] unchanged on the next block. After the block ends the same write takes effect.
- Assert rst_n=0 during S_OUT at idx=10 → q_valid=0 immediately. After release, the first output uses tbl[0] and block count restarts.

Source files
------------

// File: rtl/quant_seq_ctrl.sv
// JPEG quantization sequencer: one 23x12 unsigned multiply per coefficient against a
// 64-entry reciprocal table, with rounding (`QUANT_ROUND_EN`), sign restore and saturation.

module quant_mul #(
    parameter int A_W = 23,
    parameter int B_W = 12
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);
    assign p = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
endmodule

module quant_seq_ctrl #(
    parameter int FRAC_W = 12,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic             coef_sign,
    input  logic [22:0]      coef_mag,
    input  logic             tbl_we,
    input  logic [5:0]       tbl_addr,
    input  logic [11:0]      tbl_wdata,
    output logic             tbl_busy,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [OUT_W-1:0] q_data,
    output logic             q_last,
    output logic             q_sat
);
    localparam int MAG_W = 23;
    localparam int RCP_W = 12;
    localparam int PRD_W = MAG_W + RCP_W;
    localparam int ACC_W = 36;

`ifdef QUANT_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

    state_t             state, next_state;
    logic               accept, emit, retire;
    logic [5:0]         idx;
    logic               sign_r;
    logic [MAG_W-1:0]   mag_r;
    logic [RCP_W-1:0]   recip_r;
    logic [RCP_W-1:0]   tbl [64];

    logic [PRD_W-1:0]   product;
    logic [ACC_W-1:0]   acc, r;
    logic               sat_c;
    logic [OUT_W-1:0]   mag_c, data_c;

    quant_mul #(.A_W(MAG_W), .B_W(RCP_W)) mul_Q (
        .a (mag_r),
        .b (recip_r),
        .p (product)
    );

    always_comb begin
        acc    = {{(ACC_W-PRD_W){1'b0}}, product} + RND;
        r      = acc >> FRAC_W;
        sat_c  = (r > SAT_MAX);
        mag_c  = sat_c ? SAT_MAX[OUT_W-1:0] : r[OUT_W-1:0];
        // A negative coefficient that rounds to zero must come out as plain 0.
        data_c = (sign_r && (mag_c != '0)) ? -mag_c : mag_c;
    end

    assign tbl_busy = (idx != 6'd0) || (state != S_IDLE);

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        emit       = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: if (coef_valid && coef_ready) begin
                accept     = 1'b1;
                next_state = S_MUL;
            end
            S_MUL: begin
                emit       = 1'b1;
                next_state = S_OUT;
            end
            S_OUT: if (q_ready) begin
                retire     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            coef_ready <= 1'b0;
            idx        <= '0;
            sign_r     <= 1'b0;
            mag_r      <= '0;
            recip_r    <= '0;
            q_valid    <= 1'b0;
            q_data     <= '0;
            q_last     <= 1'b0;
            q_sat      <= 1'b0;
        end else begin
            state      <= next_state;
            coef_ready <= (next_state == S_IDLE);
            if (accept) begin
                sign_r  <= coef_sign;
                mag_r   <= coef_mag;
                recip_r <= tbl[idx];
            end
            if (emit) begin
                q_valid <= 1'b1;
                q_data  <= data_c;
                q_last  <= (idx == 6'd63);
                q_sat   <= sat_c;
            end
            if (retire) begin
                q_valid <= 1'b0;
                idx     <= idx + 6'd1;
            end
        end
    end

    // NOTE: the table is a plain RAM with no reset; software loads it before the first block.
    always_ff @(posedge clk) begin
        if (tbl_we && !tbl_busy)
            tbl[tbl_addr] <= tbl_wdata;
    end

endmodule
